key_schedule_gen: RTL and testbench

- Parametrised successor to the MacGuffin key setup. Derives ROUND_NUM round keys by chaining an external block-cipher engine over KEY_PARTS key slices. Each part encrypts its slice round-by-round over AXI4-Stream and XOR-accumulates the top RK_WIDTH bits of every result into the round-key store.
- Sits between the key register and the round-function datapath.
- Adds three things the previous version lacked: start-triggered re-keying, a variable number of key parts, and an addressed round-key read port in place of a flat array.

---
 rtl/key_schedule_pkg.sv | 32 +++
 rtl/key_schedule_gen_rk_store.sv | 43 ++++
 rtl/key_schedule_gen.sv | 169 ++++++++++++++++
 tb/tb_key_schedule_gen.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_schedule_pkg.sv
// Shared types and helpers for the round-key schedule generator.
// Used by key_schedule_gen and rk_store.
package key_schedule_pkg;

    // Schedule controller states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        RECV = 3'd3,
        DONE = 3'd4
    } ks_state_e;

    // Widest engine block the slice helper can take.
    localparam int SLICE_MAX_W = 256;

    // Index width for a counter over n items.
    // Always at least 1 bit, so a single-item range still has a usable counter.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Moves the rk_w most significant bits of a block_w-bit word down to bit 0.
    function automatic logic [SLICE_MAX_W-1:0] msb_slice(
        input logic [SLICE_MAX_W-1:0] data,
        input int                     block_w,
        input int                     rk_w
    );
        return data >> (block_w - rk_w);
    endfunction

endpackage

// File: rtl/key_schedule_gen_rk_store.sv
// Round-key register file: ROUND_NUM entries of RK_WIDTH bits.
// One write port that either overwrites or XOR-accumulates.
// One combinational read port that returns 0 for an out-of-range address.
module rk_store #(
    parameter int ROUND_NUM = 32,
    parameter int RK_WIDTH  = 48,
    parameter int ADDR_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [RK_WIDTH-1:0] wdata,
    input  logic                acc,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [RK_WIDTH-1:0] rdata
);

    logic [RK_WIDTH-1:0] mem [ROUND_NUM];

    // Wipe on reset or clear.
    // Otherwise write or accumulate into the addressed entry.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            for (int i = 0; i < ROUND_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(waddr) < ROUND_NUM)) begin
            mem[waddr] <= acc ? (mem[waddr] ^ wdata) : wdata;
        end
    end

    // Read with a range check.
    // Needed when ROUND_NUM is not a power of two.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < ROUND_NUM) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/key_schedule_gen.sv
// Round-key schedule generator.
// Chains an external block-cipher engine over the key slices using
// AXI4-Stream, and XOR-folds the result MSBs into the round-key store.
// Optional feature macro KEY_SCHEDULE_ZEROIZE_EN adds a zeroize input.
// Zeroize returns the block to IDLE and wipes the store and the block register.
module key_schedule_gen
    import key_schedule_pkg::*;
#(
    parameter int ROUND_NUM  = 32,
    parameter int BLOCK_SIZE = 64,
    parameter int KEY_PARTS  = 2,
    parameter int RK_WIDTH   = 48
) (
    input  logic                            clk,
    input  logic                            rst,
`ifdef KEY_SCHEDULE_ZEROIZE_EN
    input  logic                            zeroize,
`endif
    input  logic [KEY_PARTS*BLOCK_SIZE-1:0] key,
    input  logic                            start,
    output logic                            busy,
    output logic                            key_ready,
    output logic [BLOCK_SIZE-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    input  logic [BLOCK_SIZE-1:0]           s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [$clog2(ROUND_NUM)-1:0]    rk_addr,
    output logic [RK_WIDTH-1:0]             rk_data
);

    localparam int RND_W  = idx_w(ROUND_NUM);
    localparam int PART_W = idx_w(KEY_PARTS);
    localparam logic [RND_W-1:0]  LAST_ROUND = RND_W'(ROUND_NUM - 1);
    localparam logic [PART_W-1:0] LAST_PART  = PART_W'(KEY_PARTS - 1);

    ks_state_e                     state, state_n;
    logic [KEY_PARTS*BLOCK_SIZE-1:0] key_q;
    logic [BLOCK_SIZE-1:0]         block;
    logic [RND_W-1:0]              round;
    logic [PART_W-1:0]             part;
    logic [BLOCK_SIZE-1:0]         part_slice;
    logic [RK_WIDTH-1:0]           rk_slice;
    logic [RK_WIDTH-1:0]           rk_raw;
    logic                          wipe;
    logic                          accept_start;
    logic                          recv_fire;
    logic                          last_round;
    logic                          last_part;

`ifdef KEY_SCHEDULE_ZEROIZE_EN
    assign wipe = zeroize;
`else
    assign wipe = 1'b0;
`endif

    assign last_round   = (round == LAST_ROUND);
    assign last_part    = (part == LAST_PART);
    assign accept_start = start && !wipe && ((state == IDLE) || (state == DONE));
    assign recv_fire    = (state == RECV) && s_axis_tvalid;
    assign rk_slice     = RK_WIDTH'(msb_slice(SLICE_MAX_W'(s_axis_tdata), BLOCK_SIZE, RK_WIDTH));
    assign m_axis_tdata = block;
    assign rk_data      = key_ready ? rk_raw : '0;

    // Select key slice `part`; part 0 is the most significant slice.
    always_comb begin
        part_slice = '0;
        for (int i = 0; i < KEY_PARTS; i++) begin
            if (part == PART_W'(i)) begin
                part_slice = key_q[(KEY_PARTS-1-i)*BLOCK_SIZE +: BLOCK_SIZE];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and Moore outputs.
    // Wipe overrides everything else.
    always_comb begin
        state_n       = state;
        busy          = 1'b0;
        key_ready     = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = LOAD;
            end
            LOAD: begin
                busy    = 1'b1;
                state_n = SEND;
            end
            SEND: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) state_n = RECV;
            end
            RECV: begin
                busy          = 1'b1;
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    if (!last_round)     state_n = SEND;
                    else if (!last_part) state_n = LOAD;
                    else                 state_n = DONE;
                end
            end
            DONE: begin
                key_ready = 1'b1;
                if (start) state_n = LOAD;
            end
            default: state_n = IDLE;
        endcase
        if (wipe) state_n = IDLE;
    end

    // Key latch, block register and round/part counters.
    // The counters stop at their last value; the FSM leaves before they would wrap.
    always_ff @(posedge clk) begin
        if (!rst || wipe) begin
            key_q <= '0;
            block <= '0;
            round <= '0;
            part  <= '0;
        end else begin
            if (accept_start) begin
                key_q <= key;
                round <= '0;
                part  <= '0;
            end
            if (state == LOAD) begin
                block <= part_slice;
                round <= '0;
            end
            if (recv_fire) begin
                block <= s_axis_tdata;
                if (!last_round) begin
                    round <= round + 1'b1;
                end else if (!last_part) begin
                    part <= part + 1'b1;
                end
            end
        end
    end

    rk_store #(
        .ROUND_NUM (ROUND_NUM),
        .RK_WIDTH  (RK_WIDTH),
        .ADDR_W    (RND_W)
    ) u_rk_store (
        .clk   (clk),
        .rst   (rst),
        .clear (wipe),
        .we    (recv_fire),
        .waddr (round),
        .wdata (rk_slice),
        .acc   (part != '0),
        .raddr (rk_addr),
        .rdata (rk_raw)
    );

endmodule

// File: tb/tb_key_schedule_gen.sv
// Self-checking bench for key_schedule_gen.
// Unit A: ROUND_NUM=4, BLOCK_SIZE=16, KEY_PARTS=2, RK_WIDTH=8.
// Unit B: ROUND_NUM=5, BLOCK_SIZE=16, KEY_PARTS=3, RK_WIDTH=16 (non-power-of-two rounds, out-of-range reads).
// Engine model: result = tdata + 1, with optional ready stalls and result delays.
// Optional zeroize checks are compiled in when KEY_SCHEDULE_ZEROIZE_EN is defined.
module tb_key_schedule_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
`ifdef KEY_SCHEDULE_ZEROIZE_EN
    logic zeroize;
`endif

    // Unit A signals
    logic [31:0] key_a;
    logic        start_a, busy_a, key_ready_a;
    logic [15:0] m_tdata_a, s_tdata_a;
    logic        m_tvalid_a, m_tready_a, s_tvalid_a, s_tready_a;
    logic [1:0]  rk_addr_a;
    logic [7:0]  rk_data_a;

    // Unit B signals
    logic [47:0] key_b;
    logic        start_b, busy_b, key_ready_b;
    logic [15:0] m_tdata_b, s_tdata_b;
    logic        m_tvalid_b, m_tready_b, s_tvalid_b, s_tready_b;
    logic [2:0]  rk_addr_b;
    logic [15:0] rk_data_b;

    key_schedule_gen #(.ROUND_NUM(4), .BLOCK_SIZE(16), .KEY_PARTS(2), .RK_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst),
`ifdef KEY_SCHEDULE_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key(key_a), .start(start_a), .busy(busy_a), .key_ready(key_ready_a),
        .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tready(m_tready_a),
        .s_axis_tdata(s_tdata_a), .s_axis_tvalid(s_tvalid_a), .s_axis_tready(s_tready_a),
        .rk_addr(rk_addr_a), .rk_data(rk_data_a)
    );

    key_schedule_gen #(.ROUND_NUM(5), .BLOCK_SIZE(16), .KEY_PARTS(3), .RK_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst),
`ifdef KEY_SCHEDULE_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key(key_b), .start(start_b), .busy(busy_b), .key_ready(key_ready_b),
        .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_tready_b),
        .s_axis_tdata(s_tdata_b), .s_axis_tvalid(s_tvalid_b), .s_axis_tready(s_tready_b),
        .rk_addr(rk_addr_b), .rk_data(rk_data_b)
    );

    int total = 0;
    int bad   = 0;

    // Engine model state, indexed by unit (0 = A, 1 = B)
    bit          have[2];
    logic [15:0] res[2];
    int          wait_left[2];
    int          s_delay[2];
    int          sent[2];
    int          stall_at[2];
    int          stall_left[2];
    bit          rand_ready[2];
    bit          rand_delay[2];
    int          stall_cycles;
    logic [15:0] stall_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec-level model: round r of part p returns slice_p + r + 1.
    // rk[idx] is the XOR over all parts of the top rkw bits of that result.
    function automatic logic [15:0] ref_rk(input logic [63:0] k, input int parts, input int rounds,
                                           input int rkw, input int idx);
        logic [15:0] acc, r;
        acc = 16'h0;
        if (idx < rounds) begin
            for (int p = 0; p < parts; p++) begin
                r   = 16'(k >> (16 * (parts - 1 - p))) + 16'(idx + 1);
                acc = acc ^ 16'(r >> (16 - rkw));
            end
        end
        return acc;
    endfunction

    task automatic eng_reset(input int d);
        have[d] = 1'b0; wait_left[d] = 0; sent[d] = 0;
        if (d == 0) s_tvalid_a = 1'b0; else s_tvalid_b = 1'b0;
    endtask

    task automatic eng_step(input int d, input logic mf, input logic [15:0] md, input logic sf,
                            input logic mv_now, input logic [15:0] md_now,
                            output logic tready, output logic tvalid, output logic [15:0] tdata);
        if (sf) have[d] = 1'b0;
        if (mf) begin
            have[d]      = 1'b1;
            res[d]       = md + 16'd1;
            wait_left[d] = rand_delay[d] ? int'($urandom_range(0, 3)) : s_delay[d];
            if (d == 0 && sent[d] == stall_at[d]) stall_log.push_back(md);
            sent[d]++;
        end
        if (have[d] && wait_left[d] > 0) begin
            tvalid = 1'b0;
            wait_left[d]--;
        end else begin
            tvalid = have[d];
        end
        tdata  = tvalid ? res[d] : 16'($urandom);
        tready = rand_ready[d] ? 1'($urandom_range(0, 1)) : 1'b1;
        if (sent[d] == stall_at[d] && stall_left[d] > 0 && mv_now) begin
            tready = 1'b0;
            stall_left[d]--;
            if (d == 0) begin
                stall_cycles++;
                stall_log.push_back(md_now);
            end
        end
    endtask

    // One clock: sample handshakes before the edge, then drive engine inputs 1 time unit after it.
    task automatic tick();
        logic mf_a, sf_a, mf_b, sf_b;
        logic [15:0] md_a, md_b;
        mf_a = m_tvalid_a && m_tready_a; md_a = m_tdata_a; sf_a = s_tvalid_a && s_tready_a;
        mf_b = m_tvalid_b && m_tready_b; md_b = m_tdata_b; sf_b = s_tvalid_b && s_tready_b;
        @(posedge clk);
        #1;
        eng_step(0, mf_a, md_a, sf_a, m_tvalid_a, m_tdata_a, m_tready_a, s_tvalid_a, s_tdata_a);
        eng_step(1, mf_b, md_b, sf_b, m_tvalid_b, m_tdata_b, m_tready_b, s_tvalid_b, s_tdata_b);
    endtask

    task automatic start_a_with(input logic [31:0] k);
        key_a = k; start_a = 1'b1; sent[0] = 0;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_ready(input int d, input int budget, output int n);
        n = 0;
        while (!(d == 0 ? key_ready_a : key_ready_b) && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("ready_reached%0d", d), 64'(d == 0 ? key_ready_a : key_ready_b), 64'(1));
    endtask

    task automatic check_store(input int d, input logic [63:0] k);
        for (int a = 0; a < (d == 0 ? 4 : 8); a++) begin
            if (d == 0) rk_addr_a = 2'(a); else rk_addr_b = 3'(a);
            #1;
            chk($sformatf("rk%0d[%0d]", d, a), d == 0 ? 64'(rk_data_a) : 64'(rk_data_b),
                64'(d == 0 ? ref_rk(k, 2, 4, 8, a) : ref_rk(k, 3, 5, 16, a)));
        end
    endtask

    initial begin
        int lat, n;
        logic [31:0] k, k2;
        bit found;

        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; key_a = '0; key_b = '0;
        rk_addr_a = '0; rk_addr_b = '0;
        m_tready_a = 1'b1; s_tvalid_a = 1'b0; s_tdata_a = '0;
        m_tready_b = 1'b1; s_tvalid_b = 1'b0; s_tdata_b = '0;
`ifdef KEY_SCHEDULE_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        stall_cycles = 0;
        for (int d = 0; d < 2; d++) begin
            eng_reset(d); s_delay[d] = 0; stall_at[d] = -1; stall_left[d] = 0;
            rand_ready[d] = 1'b0; rand_delay[d] = 1'b0;
        end

        // Reset state
        tick(); tick();
        chk("rst_busy", 64'(busy_a), 64'(0));
        chk("rst_key_ready", 64'(key_ready_a), 64'(0));
        chk("rst_tvalid", 64'(m_tvalid_a), 64'(0));
        chk("rst_tready", 64'(s_tready_a), 64'(0));
        chk("rst_rk", 64'(rk_data_a), 64'(0));
        chk("rst_busy_b", 64'(busy_b), 64'(0));
        rst = 1'b1;
        tick();

        // Zero-wait engine: first beat, latency, store contents
        start_a_with(32'h1000_2000);
        lat = 1;
        chk("start_busy", 64'(busy_a), 64'(1));
        chk("load_tvalid", 64'(m_tvalid_a), 64'(0));
        tick(); lat++;
        chk("send0_tvalid", 64'(m_tvalid_a), 64'(1));
        chk("send0_tdata", 64'(m_tdata_a), 64'(16'h1000));
        wait_ready(0, 100, n); lat += n;
        chk("lat_zero_wait", 64'(lat), 64'(19));
        chk("done_busy", 64'(busy_a), 64'(0));
        check_store(0, 64'(32'h1000_2000));
        rk_addr_a = 2'd2; #1;
        chk("rk2_const", 64'(rk_data_a), 64'(8'h30));

        // Ready held low for 5 cycles on round 2 of part 0
        stall_at[0] = 2; stall_left[0] = 5; stall_cycles = 0; stall_log.delete();
        start_a_with(32'h1000_2000);
        chk("restart_ready_drop", 64'(key_ready_a), 64'(0));
        wait_ready(0, 200, n);
        chk("lat_stall", 64'(1 + n), 64'(24));
        chk("stall_cycles", 64'(stall_cycles), 64'(5));
        chk("stall_log_len", 64'(stall_log.size()), 64'(6));
        foreach (stall_log[i]) chk($sformatf("stall_tdata%0d", i), 64'(stall_log[i]), 64'(16'h1002));
        check_store(0, 64'(32'h1000_2000));
        stall_at[0] = -1;

        // Results delayed 3 cycles, garbage on tdata while invalid
        s_delay[0] = 3;
        start_a_with(32'h1000_2000);
        wait_ready(0, 300, n);
        chk("lat_delay3", 64'(1 + n), 64'(43));
        check_store(0, 64'(32'h1000_2000));
        s_delay[0] = 0;

        // Random keys and engine timing; start mid-schedule must be ignored
        rand_ready[0] = 1'b1; rand_delay[0] = 1'b1;
        for (int it = 0; it < 3; it++) begin
            k  = $urandom;
            k2 = ~k;
            start_a_with(k);
            repeat ($urandom_range(2, 15)) tick();
            key_a = k2; start_a = 1'b1;
            tick();
            start_a = 1'b0;
            chk("mid_busy", 64'(busy_a), 64'(1));
            wait_ready(0, 2000, n);
            check_store(0, 64'(k));
        end
        rand_ready[0] = 1'b0; rand_delay[0] = 1'b0;

        // Re-key from DONE
        start_a_with(32'hAAAA_5555);
        chk("rekey_ready_drop", 64'(key_ready_a), 64'(0));
        wait_ready(0, 100, n);
        check_store(0, 64'(32'hAAAA_5555));
        rk_addr_a = 2'd1; #1;
        chk("rk1_aa55", 64'(rk_data_a), 64'(8'hFF));

        // Reset during RECV of part 1
        k = $urandom;
        start_a_with(k);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (s_tready_a && sent[0] >= 5) found = 1'b1;
        end
        chk("reach_p1_recv", 64'(found), 64'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        eng_reset(0);
        chk("mid_rst_busy", 64'(busy_a), 64'(0));
        chk("mid_rst_ready", 64'(key_ready_a), 64'(0));
        chk("mid_rst_tvalid", 64'(m_tvalid_a), 64'(0));
        chk("mid_rst_tready", 64'(s_tready_a), 64'(0));
        chk("mid_rst_tdata", 64'(m_tdata_a), 64'(0));
        chk("mid_rst_rk", 64'(rk_data_a), 64'(0));
        tick();
        start_a_with(32'h1000_2000);
        wait_ready(0, 100, n);
        chk("lat_after_rst", 64'(1 + n), 64'(19));
        check_store(0, 64'(32'h1000_2000));

        // Unit B: 3 parts, 5 rounds, full-width keys, out-of-range addresses
        key_b = {16'($urandom), 32'($urandom)};
        start_b = 1'b1; sent[1] = 0;
        tick();
        start_b = 1'b0;
        wait_ready(1, 200, n);
        chk("lat_b", 64'(1 + n), 64'(34));
        check_store(1, 64'(key_b));

`ifdef KEY_SCHEDULE_ZEROIZE_EN
        // Zeroize in DONE, and zeroize winning over start
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zero_ready", 64'(key_ready_a), 64'(0));
        chk("zero_busy", 64'(busy_a), 64'(0));
        chk("zero_tdata", 64'(m_tdata_a), 64'(0));
        zeroize = 1'b1; start_a = 1'b1;
        tick();
        zeroize = 1'b0; start_a = 1'b0;
        chk("zero_over_start", 64'(busy_a), 64'(0));
        start_a_with(32'h1000_2000);
        wait_ready(0, 100, n);
        check_store(0, 64'(32'h1000_2000));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
